// File: rtl/overdrive_pkg.sv
// Shared types and helpers for the overdrive chain (pregain stage and shaper).
// Samples are signed 32-bit fixed point with the fraction width given by FRAC_BITS.
package overdrive_pkg;

  localparam int FRAC_BITS_DEF = 12;
  localparam int UNITY_GAIN    = 1 << FRAC_BITS_DEF;

  typedef logic signed [31:0] sample_t;

  typedef struct packed {
    sample_t value;
    logic    sat;
  } sat_res_t;

  localparam logic signed [63:0] S32_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] S32_MIN = 64'shFFFF_FFFF_8000_0000;

  // Rescale a full-precision product by frac_bits (floor) and clamp to 32 bits.
  function automatic sat_res_t sat_s64_to_s32(input logic signed [63:0] product,
                                              input int unsigned       frac_bits);
    logic signed [63:0] scaled;
    sat_res_t           res;
    scaled    = product >>> frac_bits;
    res.value = scaled[31:0];
    res.sat   = 1'b0;
    if (scaled > S32_MAX) begin
      res.value = 32'sh7FFF_FFFF;
      res.sat   = 1'b1;
    end else if (scaled < S32_MIN) begin
      res.value = 32'sh8000_0000;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/overdrive_gain_ramp.sv
// Working-gain tracker: latches the target on load and walks the working gain
// toward it by at most RAMP_STEP per accepted sample.
module overdrive_gain_ramp #(
  parameter int                      GAIN_W    = 16,
  parameter int                      RAMP_STEP = 16,
  parameter logic [GAIN_W-1:0]       UNITY     = 16'h1000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic              gain_load_i,
  input  logic [GAIN_W-1:0] gain_target_i,
  output logic [GAIN_W-1:0] cur_gain_o,
  output logic              ramping_o
);

  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

  logic [GAIN_W-1:0] tgt_q, tgt_d;
  logic [GAIN_W-1:0] cur_q, cur_d;
  logic              ramp_q, ramp_d;

  // The step always chases the target held before this edge, so a load that
  // coincides with a sample only influences the following sample's step.
  always_comb begin
    tgt_d = gain_load_i ? gain_target_i : tgt_q;
    cur_d = cur_q;
    if (valid_i) begin
      if (tgt_q > cur_q) begin
        cur_d = ((tgt_q - cur_q) <= STEP) ? tgt_q : cur_q + STEP;
      end else if (tgt_q < cur_q) begin
        cur_d = ((cur_q - tgt_q) <= STEP) ? tgt_q : cur_q - STEP;
      end
    end
    ramp_d = (cur_d != tgt_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tgt_q  <= UNITY;
      cur_q  <= UNITY;
      ramp_q <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      ramp_q <= ramp_d;
    end
  end

  assign cur_gain_o = cur_q;
  assign ramping_o  = ramp_q;

endmodule

// File: rtl/overdrive_pregain.sv
// Drive stage ahead of the overdrive shaper: sample * ramped gain, floor-rescaled
// and saturated to 32 bits, three register stages (sample -> product -> result).
module overdrive_pregain
  import overdrive_pkg::*;
#(
  parameter int FRAC_BITS = 12,
  parameter int GAIN_W    = 16,
  parameter int RAMP_STEP = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [31:0]       i_sample,
  input  logic              i_gain_load,
  input  logic [GAIN_W-1:0] i_gain_target,
  input  logic              i_bypass,
  output logic              o_valid,
  output logic [31:0]       o_sample,
  output logic              o_sat,
  output logic              o_ramping
);

  localparam int                STAGES = 2;
  localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(64'd1 << FRAC_BITS);

  logic [STAGES:0]    vld_pipe_q;
  logic [GAIN_W-1:0]  cur_gain;
  logic               ramping;

  sample_t            s0_sample_q;
  logic [GAIN_W-1:0]  s0_gain_q;
  logic               s0_byp_q;

  logic signed [63:0] s1_prod_q, s1_prod_d;
  sample_t            s1_sample_q;
  logic               s1_byp_q;

  sat_res_t           s2_res;
  logic [31:0]        out_sample_q;
  logic               out_sat_q;

  overdrive_gain_ramp #(
    .GAIN_W   (GAIN_W),
    .RAMP_STEP(RAMP_STEP),
    .UNITY    (UNITY)
  ) u_ramp (
    .clk_i        (i_clk),
    .rst_n_i      (i_rst_n),
    .valid_i      (i_valid),
    .gain_load_i  (i_gain_load),
    .gain_target_i(i_gain_target),
    .cur_gain_o   (cur_gain),
    .ramping_o    (ramping)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_pipe_q <= '0;
    else          vld_pipe_q <= {vld_pipe_q[STAGES-1:0], i_valid};
  end

  // S0: capture sample with the gain in force before this edge's ramp step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_sample_q <= '0;
      s0_gain_q   <= '0;
      s0_byp_q    <= 1'b0;
    end else if (i_valid) begin
      s0_sample_q <= sample_t'(i_sample);
      s0_gain_q   <= cur_gain;
      s0_byp_q    <= i_bypass;
    end
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign s1_prod_d = 64'(s0_sample_q) * 64'(signed'({1'b0, s0_gain_q}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_prod_q   <= '0;
      s1_sample_q <= '0;
      s1_byp_q    <= 1'b0;
    end else if (vld_pipe_q[0]) begin
      s1_prod_q   <= s1_prod_d;
      s1_sample_q <= s0_sample_q;
      s1_byp_q    <= s0_byp_q;
    end
  end

  always_comb begin
    s2_res = sat_s64_to_s32(s1_prod_q, FRAC_BITS);
    if (s1_byp_q) begin
      s2_res.value = s1_sample_q;
      s2_res.sat   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_sample_q <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      out_sat_q <= vld_pipe_q[1] & s2_res.sat;
      if (vld_pipe_q[1]) out_sample_q <= s2_res.value;
    end
  end

  assign o_valid   = vld_pipe_q[STAGES];
  assign o_sample  = out_sample_q;
  assign o_sat     = out_sat_q;
  assign o_ramping = ramping;

endmodule

// File: tb/tb_overdrive_pregain.sv
// Randomized bench for overdrive_pregain against a cycle-indexed arithmetic model.
module tb_overdrive_pregain;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_sample = '0;
  logic        i_gain_load = 1'b0;
  logic [15:0] i_gain_target = '0;
  logic        i_bypass = 1'b0;
  logic        o_valid;
  logic [31:0] o_sample;
  logic        o_sat;
  logic        o_ramping;

  always #5 i_clk = ~i_clk;

  overdrive_pregain dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sample(i_sample),
    .i_gain_load(i_gain_load), .i_gain_target(i_gain_target), .i_bypass(i_bypass),
    .o_valid(o_valid), .o_sample(o_sample), .o_sat(o_sat), .o_ramping(o_ramping)
  );

  typedef struct {
    logic        v;
    logic [31:0] s;
    logic        b;
    logic        ld;
    logic [15:0] t;
  } stim_t;

  localparam int     MSK  = 8191;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_cur  = 4096;
  int m_tgt  = 4096;
  logic        ev   [0:MSK];
  logic [31:0] es   [0:MSK];
  logic        esat [0:MSK];

  function automatic int ramp_next(input int c, input int t);
    if ((t - c) <= 16 && (c - t) <= 16) return t;
    return (t > c) ? c + 16 : c - 16;
  endfunction

  function automatic logic [32:0] gained(input logic [31:0] s, input int g);
    longint p, sc;
    p  = longint'($signed(s)) * longint'(g);
    sc = p >>> 12;
    if (sc > MAXV) return {1'b1, 32'h7FFF_FFFF};
    if (sc < MINV) return {1'b1, 32'h8000_0000};
    return {1'b0, sc[31:0]};
  endfunction

  // Drive one cycle and advance the model; checking is left to each test.
  task automatic step(input stim_t st);
    logic [32:0] r;
    int k;
    i_valid = st.v; i_sample = st.s; i_bypass = st.b;
    i_gain_load = st.ld; i_gain_target = st.t;
    @(posedge i_clk);
    cyc++;
    if (st.v) begin
      r = st.b ? {1'b0, st.s} : gained(st.s, m_cur);
      k = (cyc + 2) & MSK;
      ev[k] = 1'b1; es[k] = r[31:0]; esat[k] = r[32];
      m_cur = ramp_next(m_cur, m_tgt);
    end
    if (st.ld) m_tgt = int'(st.t);
    @(negedge i_clk);
    i_valid = 1'b0; i_gain_load = 1'b0; i_bypass = 1'b0;
  endtask

  task automatic assert_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_gain_load = 1'b0; i_bypass = 1'b0;
    m_cur = 4096; m_tgt = 4096;
    for (int i = 0; i <= MSK; i++) ev[i] = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  function automatic stim_t mk(input logic v, input logic [31:0] s, input logic b,
                               input logic ld, input logic [15:0] t);
    stim_t st;
    st.v = v; st.s = s; st.b = b; st.ld = ld; st.t = t;
    return st;
  endfunction

  function automatic logic [31:0] small_rand();
    return $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
  endfunction

  task automatic test_reset();
    assert_reset();
    checks += 4;
    if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    if (o_sample !== 32'h0) begin errors++; $display("FAIL reset_sample got=%h want=0", o_sample); end
    if (o_sat !== 1'b0)     begin errors++; $display("FAIL reset_sat got=%b want=0", o_sat); end
    if (o_ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping got=%b want=0", o_ramping); end
    release_reset();
  endtask

  task automatic test_basic();
    stim_t q[$];
    int k;
    q.push_back(mk(1, 32'h0000_1234, 0, 0, 0));
    q.push_back(mk(1, 32'hFFFF_F000, 0, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL basic_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL basic_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL basic_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
  endtask

  task automatic test_ramp_up();
    stim_t q[$];
    int k, ramp_samples;
    logic prev_ramp;
    ramp_samples = 0;
    q.push_back(mk(0, 0, 0, 1, 16'h2000));
    for (int i = 0; i < 270; i++) q.push_back(mk(1, small_rand(), 0, 0, 0));
    q.push_back(mk(1, 32'h0000_1000, 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      prev_ramp = o_ramping;
      step(q[i]);
      if (q[i].v && prev_ramp) ramp_samples++;
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL ramp_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL ramp_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL ramp_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL ramp_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
    checks++;
    if (ramp_samples != 256) begin errors++; $display("FAIL ramp_length got=%0d want=256", ramp_samples); end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    int k;
    q.push_back(mk(1, 32'h7000_0000, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 1, 16'h4000));
    for (int i = 0; i < 130; i++) q.push_back(mk(1, small_rand(), 0, 0, 0));
    q.push_back(mk(1, 32'hC000_0000, 0, 0, 0));
    q.push_back(mk(1, 32'hF000_0000, 0, 0, 0));
    q.push_back(mk(1, 32'h8000_0000, 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL sat_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL sat_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL sat_flag cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL sat_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
  endtask

  task automatic test_load_with_valid();
    stim_t q[$];
    int k;
    assert_reset();
    release_reset();
    q.push_back(mk(1, 32'h0000_1000, 0, 1, 16'h0000));
    for (int i = 0; i < 262; i++) q.push_back(mk(1, $urandom(), 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL ldv_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL ldv_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL ldv_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL ldv_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
    checks++;
    if (o_sample !== 32'h0) begin errors++; $display("FAIL ldv_final_zero got=%h want=0", o_sample); end
  endtask

  task automatic test_bypass();
    stim_t q[$];
    int k;
    assert_reset();
    release_reset();
    q.push_back(mk(0, 0, 0, 1, 16'h3000));
    q.push_back(mk(1, 32'h7FFF_FFFF, 1, 0, 0));
    for (int i = 0; i < 20; i++) q.push_back(mk(1, $urandom(), 1, 0, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 32'h0000_1000, 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL byp_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL byp_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL byp_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL byp_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
  endtask

  task automatic test_random();
    stim_t q[$];
    int k;
    logic [15:0] t;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       t = 16'h0000;
        1:       t = 16'hFFFF;
        default: t = 16'($urandom_range(0, 65535));
      endcase
      q.push_back(mk($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 40) == 0, t));
    end
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL rnd_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL rnd_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL rnd_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
  endtask

  task automatic test_reset_midstream();
    stim_t q[$];
    int k;
    step(mk(1, 32'h0001_0000, 0, 1, 16'h3000));
    step(mk(1, 32'h0002_0000, 0, 0, 0));
    assert_reset();
    checks += 3;
    if (o_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
    if (o_sat !== 1'b0)     begin errors++; $display("FAIL midrst_sat got=%b want=0", o_sat); end
    if (o_ramping !== 1'b0) begin errors++; $display("FAIL midrst_ramping got=%b want=0", o_ramping); end
    release_reset();
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 0, 0));
    q.push_back(mk(1, 32'h0000_1000, 0, 0, 0));
    q.push_back(mk(1, 32'hFFFF_F000, 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
    foreach (q[i]) begin
      step(q[i]);
      k = cyc & MSK;
      checks += 3;
      if (o_valid !== ev[k]) begin errors++; $display("FAIL postrst_valid cyc=%0d got=%b want=%b", cyc, o_valid, ev[k]); end
      if (ev[k] && o_sample !== es[k]) begin errors++; $display("FAIL postrst_sample cyc=%0d got=%h want=%h", cyc, o_sample, es[k]); end
      if (o_sat !== (ev[k] & esat[k])) begin errors++; $display("FAIL postrst_sat cyc=%0d got=%b want=%b", cyc, o_sat, ev[k] & esat[k]); end
      checks++;
      if (o_ramping !== (m_cur != m_tgt)) begin errors++; $display("FAIL postrst_ramping cyc=%0d got=%b want=%b", cyc, o_ramping, m_cur != m_tgt); end
      ev[k] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i <= MSK; i++) begin
      ev[i] = 1'b0; es[i] = '0; esat[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_ramp_up();
    test_saturation();
    test_load_with_valid();
    test_bypass();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
